icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the multi-cycle CPU instruction fetch channel and the memory read channel.
- Accepts one fetch address at a time and returns the 32-bit instruction word.
- On a miss, fetches the whole line with a burst read, installs it, then answers the CPU.
- Exposes hit/miss counters for the CPU performance-counter bank.

---
 rtl/icache_direct_if.sv | 33 +++
 rtl/icache_direct.sv | 129 ++++++++++++
 tb/tb_icache_direct.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// Fetch and line-refill channels of the direct-mapped instruction cache.
// The slave modport is the cache's view. The master modport is the CPU/memory side.
interface icache_direct_if;
  logic        from_cpu_inst_req_valid;
  logic [31:0] from_cpu_inst_req_addr;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready;
  logic        from_mem_rd_rsp_valid;
  logic [31:0] from_mem_rd_rsp_data;
  logic        from_mem_rd_rsp_last;
  logic        to_mem_rd_rsp_ready;

  modport slave (
    input  from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
           from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
           from_mem_rd_rsp_last,
    output to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
           to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );

  modport master (
    output from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
           from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
           from_mem_rd_rsp_last,
    input  to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
           to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: one fetch at a time, whole-line burst refill on miss,
// with hit and miss counters for the performance-counter bank.
module icache_direct #(
  parameter int SET_NUM    = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  icache_direct_if.slave    bus,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    S_WAIT, S_TAG_RD, S_MEM_RD, S_RECV, S_REFILL, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [31:2]       addr_q;
  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic [WORD_W-1:0] addr_word;

  logic [SET_NUM-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [SET_NUM];
  logic [31:0]        data_q [SET_NUM][LINE_WORDS];
  logic [31:0]        line_buf [LINE_WORDS];
  logic [WORD_W-1:0]  beat_cnt;
  logic [31:0]        rsp_data;
  logic [31:0]        mem_addr;
  logic               hit;
  logic               beat_fire;

  assign addr_tag  = addr_q[31 -: TAG_W];
  assign addr_idx  = addr_q[OFF_W +: IDX_W];
  assign addr_word = addr_q[2 +: WORD_W];
  assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign beat_fire = (state == S_RECV) && bus.from_mem_rd_rsp_valid;

  assign bus.to_cpu_cache_rsp_data = rsp_data;
  assign bus.to_mem_rd_req_addr    = mem_addr;

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_nxt                    = state;
    bus.to_cpu_inst_req_ready    = 1'b0;
    bus.to_cpu_cache_rsp_valid   = 1'b0;
    bus.to_mem_rd_req_valid      = 1'b0;
    bus.to_mem_rd_rsp_ready      = 1'b0;
    case (state)
      S_WAIT: begin
        bus.to_cpu_inst_req_ready = 1'b1;
        if (bus.from_cpu_inst_req_valid) state_nxt = S_TAG_RD;
      end
      S_TAG_RD: state_nxt = hit ? S_RESP : S_MEM_RD;
      S_MEM_RD: begin
        // Handshakes are masked by rst so an abort is visible in the same cycle.
        bus.to_mem_rd_req_valid = !rst;
        if (bus.from_mem_rd_req_ready) state_nxt = S_RECV;
      end
      S_RECV: begin
        bus.to_mem_rd_rsp_ready = !rst;
        if (bus.from_mem_rd_rsp_valid && bus.from_mem_rd_rsp_last) state_nxt = S_REFILL;
      end
      S_REFILL: state_nxt = S_RESP;
      S_RESP: begin
        bus.to_cpu_cache_rsp_valid = !rst;
        if (bus.from_cpu_cache_rsp_ready) state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      valid_q  <= '0;
      beat_cnt <= '0;
      rsp_data <= '0;
      mem_addr <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        S_WAIT:
          if (bus.from_cpu_inst_req_valid) addr_q <= bus.from_cpu_inst_req_addr[31:2];
        S_TAG_RD:
          if (hit) begin
            rsp_data <= data_q[addr_idx][addr_word];
            hit_cnt  <= hit_cnt + 32'd1;
          end else begin
            mem_addr <= {addr_tag, addr_idx, {OFF_W{1'b0}}};
          end
        S_MEM_RD:
          if (bus.from_mem_rd_req_ready) beat_cnt <= '0;
        S_RECV:
          if (bus.from_mem_rd_rsp_valid) beat_cnt <= beat_cnt + 1'b1;
        S_REFILL: begin
          valid_q[addr_idx] <= 1'b1;
          rsp_data          <= line_buf[addr_word];
          miss_cnt          <= miss_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag, data and line-buffer storage is deliberately not reset; the valid bits alone
  // decide whether a set's contents mean anything, so resetting the arrays only costs logic.
  always_ff @(posedge clk) begin
    if (beat_fire) line_buf[beat_cnt] <= bus.from_mem_rd_rsp_data;
    if (state == S_REFILL) begin
      tag_q[addr_idx]  <= addr_tag;
      data_q[addr_idx] <= line_buf;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Directed test of icache_direct: cold miss, hit, conflict, backpressure, reset abort and top index.
module tb_icache_direct;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int          total = 0;
  int          bad   = 0;

  icache_direct_if bus();

  icache_direct dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.from_cpu_inst_req_valid  = 1'b0;
    bus.from_cpu_inst_req_addr   = '0;
    bus.from_cpu_cache_rsp_ready = 1'b0;
    bus.from_mem_rd_req_ready    = 1'b0;
    bus.from_mem_rd_rsp_valid    = 1'b0;
    bus.from_mem_rd_rsp_data     = '0;
    bus.from_mem_rd_rsp_last     = 1'b0;
  endtask

  // Issues one request and accepts the CPU handshake; left at the negedge of the TAG_RD cycle.
  task automatic issue(input logic [31:0] addr);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.to_cpu_inst_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", {31'd0, bus.to_cpu_inst_req_ready}, 32'd1);
    bus.from_cpu_inst_req_valid = 1'b1;
    bus.from_cpu_inst_req_addr  = addr;
    @(negedge clk);
    bus.from_cpu_inst_req_valid = 1'b0;
    check("busy_after_accept", {31'd0, bus.to_cpu_inst_req_ready}, 32'd0);
  endtask

  // Waits for the line request, checks its address, stalls, then accepts it.
  task automatic mem_request(input logic [31:0] addr, input int req_stall);
    int n;
    logic [31:0] line_addr;
    line_addr = addr & 32'hFFFF_FFE0;
    @(negedge clk);
    n = 0;
    while (!bus.to_mem_rd_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mem_req_valid", {31'd0, bus.to_mem_rd_req_valid}, 32'd1);
    check("mem_req_addr", bus.to_mem_rd_req_addr, line_addr);
    for (int i = 0; i < req_stall; i++) begin
      @(negedge clk);
      check("mem_req_hold_valid", {31'd0, bus.to_mem_rd_req_valid}, 32'd1);
      check("mem_req_hold_addr", bus.to_mem_rd_req_addr, line_addr);
    end
    bus.from_mem_rd_req_ready = 1'b1;
    @(negedge clk);
    bus.from_mem_rd_req_ready = 1'b0;
    check("mem_req_dropped", {31'd0, bus.to_mem_rd_req_valid}, 32'd0);
  endtask

  // Sends beats [0, nbeats) of a line whose word i is base+i; last rides on beat 7 only.
  task automatic send_beats(input logic [31:0] base, input int nbeats, input int beat_gap);
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) repeat (beat_gap) @(negedge clk);
      bus.from_mem_rd_rsp_valid = 1'b1;
      bus.from_mem_rd_rsp_data  = base + i;
      bus.from_mem_rd_rsp_last  = (i == 7);
      check("beat_ready", {31'd0, bus.to_mem_rd_rsp_ready}, 32'd1);
      @(negedge clk);
      bus.from_mem_rd_rsp_valid = 1'b0;
      bus.from_mem_rd_rsp_last  = 1'b0;
    end
  endtask

  // Full fetch; for a miss the line returned by memory holds base+i in word i.
  task automatic fetch(input logic [31:0] addr, input bit miss, input logic [31:0] base,
                       input logic [31:0] exp_word, input int req_stall, input int beat_gap,
                       input int rsp_stall);
    issue(addr);
    check("no_rsp_in_tag_rd", {31'd0, bus.to_cpu_cache_rsp_valid}, 32'd0);
    if (!miss) begin
      @(negedge clk);
      check("hit_rsp_latency", {31'd0, bus.to_cpu_cache_rsp_valid}, 32'd1);
      check("hit_no_mem_req", {31'd0, bus.to_mem_rd_req_valid}, 32'd0);
    end else begin
      mem_request(addr, req_stall);
      send_beats(base, 8, beat_gap);
      // The single REFILL cycle sits between the last beat and the response.
      check("no_rsp_in_refill", {31'd0, bus.to_cpu_cache_rsp_valid}, 32'd0);
      @(negedge clk);
      check("miss_rsp_latency", {31'd0, bus.to_cpu_cache_rsp_valid}, 32'd1);
    end
    check("rsp_data", bus.to_cpu_cache_rsp_data, exp_word);
    for (int i = 0; i < rsp_stall; i++) begin
      @(negedge clk);
      check("rsp_hold_valid", {31'd0, bus.to_cpu_cache_rsp_valid}, 32'd1);
      check("rsp_hold_data", bus.to_cpu_cache_rsp_data, exp_word);
    end
    bus.from_cpu_cache_rsp_ready = 1'b1;
    @(negedge clk);
    bus.from_cpu_cache_rsp_ready = 1'b0;
    check("rsp_dropped", {31'd0, bus.to_cpu_cache_rsp_valid}, 32'd0);
    check("back_to_wait", {31'd0, bus.to_cpu_inst_req_ready}, 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_req_valid", {31'd0, bus.to_mem_rd_req_valid}, 32'd0);
    check("rst_mem_rsp_ready", {31'd0, bus.to_mem_rd_rsp_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.to_cpu_inst_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.to_cpu_cache_rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.to_cpu_cache_rsp_data, 32'd0);
    check("rst_mem_addr", bus.to_mem_rd_req_addr, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);

    // Cold miss, then a hit in the same line (word 3).
    fetch(32'h0000_0040, 1'b1, 32'h100, 32'h100, 0, 0, 0);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);
    fetch(32'h0000_004C, 1'b0, 32'h0, 32'h103, 0, 0, 0);
    check("hit_cnt_1", hit_cnt, 32'd1);

    // 0x140 shares index 2 with 0x40: each evicts the other.
    fetch(32'h0000_0140, 1'b1, 32'h200, 32'h200, 0, 0, 0);
    fetch(32'h0000_0040, 1'b1, 32'h100, 32'h100, 0, 0, 0);
    check("conflict_miss_cnt", miss_cnt, 32'd3);
    check("conflict_hit_cnt", hit_cnt, 32'd1);

    // Backpressure on every channel; word 2 of the 0x140 line.
    fetch(32'h0000_0148, 1'b1, 32'h200, 32'h202, 5, 2, 3);
    check("bp_miss_cnt", miss_cnt, 32'd4);
    check("bp_hit_cnt", hit_cnt, 32'd1);

    // Reset after 3 beats of a refill aborts it.
    issue(32'h0000_0080);
    mem_request(32'h0000_0080, 0);
    send_beats(32'h300, 3, 0);
    rst = 1'b1;
    #1;
    check("abort_beat_ready_drop", {31'd0, bus.to_mem_rd_rsp_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_ready", {31'd0, bus.to_cpu_inst_req_ready}, 32'd1);
    check("abort_hit_cnt", hit_cnt, 32'd0);
    check("abort_miss_cnt", miss_cnt, 32'd0);
    fetch(32'h0000_0080, 1'b1, 32'h300, 32'h300, 0, 0, 0);
    check("refetch_miss_cnt", miss_cnt, 32'd1);

    // Last index, last word, all-ones tag.
    fetch(32'hFFFF_FFFC, 1'b1, 32'h900, 32'h907, 0, 1, 0);
    fetch(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h907, 0, 0, 1);
    check("top_miss_cnt", miss_cnt, 32'd2);
    check("top_hit_cnt", hit_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
